// File: rtl/r4_pkg.sv
// r4_pkg: shared definitions for the radix-4 butterfly Wishbone responder.
//   - DW: butterfly data width per component
//   - register offsets inside the 16-byte window
//   - run-control FSM state type
package r4_pkg;

    localparam int DW = 4;

    localparam logic [3:0] OPERAND_OFS = 4'h0;
    localparam logic [3:0] CTRL_OFS    = 4'h4;
    localparam logic [3:0] STATUS_OFS  = 4'h8;
    localparam logic [3:0] RESULT_OFS  = 4'hC;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } r4_state_e;

endpackage

// File: rtl/r4_result_fifo.sv
// r4_result_fifo: synchronous FIFO holding captured butterfly samples.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : synchronous flush (start of a new run)
//   push_i       : write wdata_i (dropped only if full and not popping)
//   pop_i        : remove head entry (ignored when empty)
//   rdata_o      : head entry, meaningful only when !empty_o
//   count_o      : number of stored entries
//   empty_o      : no entries stored
module r4_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          pop_ok, push_ok;

    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);
    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/r4_wb_responder.sv
// r4_wb_responder: Wishbone classic slave driving the radix-4 butterfly.
//   CLK, RST          : clock, synchronous active-high reset
//   wbs_*             : Wishbone slave port (sel ignored, full-word access)
//   xr0..xr3/xi0..xi3 : operand outputs to the butterfly (OPERAND register)
//   c1, c2, c3        : butterfly control selects (CTRL register)
//   Xro, Xio          : butterfly outputs, captured N_OUT cycles per run
//   dbg_state_o       : current run-control FSM state
// Bus handshake (valid/ready): a request is stb & cyc & address in window;
// it is accepted on an edge where ack is low, ack is high for exactly the
// following cycle, and all side effects take place on that accepting edge.
// wbs_dat_o carries read data only while ack is high, otherwise 0.
import r4_pkg::*;

module r4_wb_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          LATENCY   = 2,
    parameter int          N_OUT     = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wbs_stb_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic [DW-1:0] xr0,
    output logic [DW-1:0] xr1,
    output logic [DW-1:0] xr2,
    output logic [DW-1:0] xr3,
    output logic [DW-1:0] xi0,
    output logic [DW-1:0] xi1,
    output logic [DW-1:0] xi2,
    output logic [DW-1:0] xi3,
    output logic          c1,
    output logic          c2,
    output logic          c3,
    input  logic [DW-1:0] Xro,
    input  logic [DW-1:0] Xio,
    output logic [1:0]    dbg_state_o
);
    localparam int CNT_MAX = (LATENCY > N_OUT) ? LATENCY : N_OUT;
    localparam int CNTW    = $clog2(CNT_MAX + 1);
    localparam int FCW     = $clog2(N_OUT + 1);

    r4_state_e       state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [31:0]     operand_q;
    logic [2:0]      c_q;
    logic            done_q;
    logic            ack_q;
    logic [31:0]     dat_q;

    logic            in_win, accept, wr, rd, busy;
    logic [3:0]      ofs;
    logic            start, push, fin, pop;
    logic [31:0]     rd_data;
    logic [2*DW-1:0] fifo_rdata;
    logic [FCW-1:0]  fifo_count;
    logic            fifo_empty;
    logic            unused_sel;

    assign unused_sel = ^wbs_sel_i;

    assign in_win = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign accept = wbs_stb_i && wbs_cyc_i && in_win && !ack_q;
    assign wr     = accept && wbs_we_i;
    assign rd     = accept && !wbs_we_i;
    assign ofs    = wbs_adr_i[3:0];
    assign busy   = (state_q != IDLE);
    assign pop    = rd && (ofs == RESULT_OFS) && !fifo_empty;

    // Run control: start only from IDLE, so a start in the completing cycle
    // (state still CAPTURE) or during a run is dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        push    = 1'b0;
        fin     = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr && (ofs == CTRL_OFS) && wbs_dat_i[0]) begin
                    start   = 1'b1;
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (cnt_q == CNTW'(LATENCY - 1)) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAPTURE: begin
                push = 1'b1;
                if (cnt_q == CNTW'(N_OUT - 1)) begin
                    fin     = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (ofs)
            OPERAND_OFS: rd_data = operand_q;
            CTRL_OFS:    rd_data = {28'b0, c_q, 1'b0};
            STATUS_OFS:  rd_data = {26'b0, 4'(fifo_count), done_q, busy};
            RESULT_OFS:  rd_data = fifo_empty ? 32'b0 : {1'b1, 23'b0, fifo_rdata};
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            operand_q <= '0;
            c_q       <= '0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= accept;
            dat_q   <= rd ? rd_data : 32'b0;
            if (wr && !busy && (ofs == OPERAND_OFS)) begin
                operand_q <= wbs_dat_i;
            end
            if (wr && !busy && (ofs == CTRL_OFS)) begin
                c_q <= wbs_dat_i[3:1];
            end
            if (start) begin
                done_q <= 1'b0;
            end else if (fin) begin
                done_q <= 1'b1;
            end
        end
    end

    r4_result_fifo #(
        .DEPTH (N_OUT),
        .W     (2*DW)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .clr_i   (start),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({Xio, Xro}),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign {xi3, xi2, xi1, xi0, xr3, xr2, xr1, xr0} = operand_q;
    assign {c3, c2, c1} = c_q;
    assign dbg_state_o = state_q;

endmodule
